// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one three-operand serial adder among NREQ requesters,
// returning each sum tagged with the requester ID.
module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic [1:0]        op_idx,
  output logic              add_irdy,
  output logic [W-1:0]      add_din,
  input  logic [W-1:0]      add_dout,
  input  logic              add_ordy,
  output logic              res_valid,
  output logic [2:0]        res_id,
  output logic [W-1:0]      res_dout,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, FEED0, FEED1, FEED2, WAIT} state_t;
  state_t state, state_nx;
  logic [2:0] ptr, cur_id, win, nxt_ptr;
  logic [1:0] tmo;
  logic       feed;
  // Scanning downward from the farthest offset leaves the nearest requester at or above ptr as winner
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) win = 3'((int'(ptr) + k) % NREQ);
  end
  assign nxt_ptr = (cur_id == 3'(NREQ - 1)) ? 3'd0 : cur_id + 3'd1;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |req ? FEED0 : IDLE;
      FEED0:   state_nx = FEED1;
      FEED1:   state_nx = FEED2;
      FEED2:   state_nx = WAIT;
      WAIT:    state_nx = (add_ordy || tmo == 2'd3) ? IDLE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      tmo       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_dout  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      res_valid <= 1'b0;
      err       <= 1'b0;
      if (state == IDLE && |req) cur_id <= win;
      if (state == FEED2) tmo <= '0;
      if (state == WAIT) begin
        if (add_ordy) begin
          res_dout  <= add_dout;
          res_id    <= cur_id;
          res_valid <= 1'b1;
          ptr       <= nxt_ptr;
        end else if (tmo == 2'd3) begin
          err <= 1'b1;
          ptr <= nxt_ptr;
        end else begin
          tmo <= tmo + 2'd1;
        end
      end
    end
  end
  assign feed     = state == FEED0 || state == FEED1 || state == FEED2;
  assign gnt      = feed ? {{(NREQ-1){1'b0}}, 1'b1} << cur_id : '0;
  assign add_irdy = state == FEED0;
  assign op_idx   = state == FEED1 ? 2'd1 : state == FEED2 ? 2'd2 : 2'd0;
  assign add_din  = feed ? req_din[W*cur_id +: W] : '0;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: table-driven and sequence checks of adder_share_arbiter against a
// behavioural serial adder and a result scoreboard.
module tb_adder_share_arbiter;
  localparam int N = 4, W = 16;
  logic clk = 0, reset = 0, tie_off = 0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_din;
  logic [N-1:0] gnt;
  logic [1:0] op_idx;
  logic add_irdy, add_ordy, res_valid, err;
  logic [W-1:0] add_din, add_dout, res_dout, acc;
  logic [2:0] res_id;
  logic [W-1:0] ops [N][4];
  int checks = 0, failures = 0;
  typedef struct {logic [2:0] id; logic [W-1:0] sum;} res_t;
  typedef struct {logic [N-1:0] r; logic [W-1:0] o0, o1, o2; logic [2:0] id; logic [W-1:0] sum;} vec_t;
  res_t sbq[$];
  res_t mon_r;
  vec_t vecs[4];

  always #5 clk = ~clk;

  adder_share_arbiter #(.NREQ(N), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_din(req_din), .gnt(gnt), .op_idx(op_idx),
    .add_irdy(add_irdy), .add_din(add_din), .add_dout(add_dout), .add_ordy(add_ordy),
    .res_valid(res_valid), .res_id(res_id), .res_dout(res_dout), .err(err));

  always_comb
    for (int i = 0; i < N; i++) req_din[i*W +: W] = gnt[i] ? ops[i][op_idx] : '0;

  // Conforming adder: clears ordy on the first operand, sets it with the sum on the third
  always @(posedge clk or negedge reset)
    if (!reset) begin
      acc <= '0; add_dout <= '0; add_ordy <= 1'b0;
    end else if (add_irdy) begin
      acc <= add_din; add_ordy <= 1'b0;
    end else if (gnt != '0 && op_idx == 2'd1) begin
      acc <= acc + add_din;
    end else if (gnt != '0 && op_idx == 2'd2) begin
      add_dout <= acc + add_din; add_ordy <= !tie_off;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    if (res_valid) begin
      if (sbq.size() == 0) chk("res_valid_unexpected", res_valid, 0);
      else begin
        mon_r = sbq.pop_front();
        chk("res_id", res_id, mon_r.id);
        chk("res_dout", res_dout, mon_r.sum);
      end
    end
  end

  task automatic idle_outputs(input string nm);
    chk({nm, "_gnt"}, gnt, 0);
    chk({nm, "_irdy"}, add_irdy, 0);
    chk({nm, "_op_idx"}, op_idx, 0);
    chk({nm, "_add_din"}, add_din, 0);
    chk({nm, "_res_valid"}, res_valid, 0);
    chk({nm, "_res_id"}, res_id, 0);
    chk({nm, "_res_dout"}, res_dout, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    reset = 0;
    req = '0;
    repeat (2) @(negedge clk);
    idle_outputs("reset");
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
  endtask

  task automatic run(input logic [N-1:0] r, input int n, input int drop);
    req = r;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      chk("res_valid_timing", res_valid, 32'(c % 5 == 0));
      if (c == drop) req = '0;
    end
  endtask

  task automatic push(input logic [2:0] id, input logic [W-1:0] sum);
    res_t r;
    r.id = id;
    r.sum = sum;
    sbq.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) for (int k = 0; k < 4; k++) ops[i][k] = '0;
    vecs[0] = '{4'b0100, 16'h0001, 16'h0002, 16'h0003, 3'd2, 16'h0006};
    vecs[1] = '{4'b0001, 16'hFFFF, 16'h0002, 16'h0000, 3'd0, 16'h0001};
    vecs[2] = '{4'b1000, 16'h1234, 16'h1111, 16'h0F0F, 3'd3, 16'h3254};
    vecs[3] = '{4'b0010, 16'h8000, 16'h8000, 16'h7FFF, 3'd1, 16'h7FFF};
    do_reset();
    foreach (vecs[v]) begin
      logic [W-1:0] e[3];
      e = '{vecs[v].o0, vecs[v].o1, vecs[v].o2};
      for (int k = 0; k < 3; k++) ops[vecs[v].id][k] = e[k];
      push(vecs[v].id, vecs[v].sum);
      req = vecs[v].r;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (c <= 3) begin
          chk("feed_gnt", gnt, 4'b0001 << vecs[v].id);
          chk("feed_irdy", add_irdy, 32'(c == 1));
          chk("feed_op_idx", op_idx, c - 1);
          chk("feed_add_din", add_din, e[c-1]);
        end
        if (c == 1) req = '0;
        if (c == 4) begin
          chk("wait_gnt", gnt, 0);
          chk("wait_res_valid", res_valid, 0);
        end
        if (c == 5) chk("res_valid_c5", res_valid, 1);
      end
    end
    // ptr is now 2; abort a transaction in FEED1
    ops[2][0] = 16'h5; ops[2][1] = 16'h6; ops[2][2] = 16'h7;
    req = 4'b0100;
    repeat (2) @(negedge clk);
    chk("abort_op_idx_before", op_idx, 1);
    reset = 0;
    #1 idle_outputs("abort");
    req = '0;
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    ops[1][0] = 16'd10; ops[1][1] = 16'd20; ops[1][2] = 16'd30;
    push(3'd1, 16'd60);
    run(4'b0110, 6, 1);
    push(3'd0, 16'h0001);
    run(4'b0001, 5, 1);
    // all four requesters held
    do_reset();
    ops[0][0] = 16'h1; ops[0][1] = 16'h1; ops[0][2] = 16'h1;
    ops[1][0] = 16'h100; ops[1][1] = 16'h200; ops[1][2] = 16'h300;
    ops[2][0] = 16'hAAAA; ops[2][1] = 16'h5555; ops[2][2] = 16'h1;
    ops[3][0] = 16'h7000; ops[3][1] = 16'h7000; ops[3][2] = 16'h7000;
    push(3'd0, 16'h0003); push(3'd1, 16'h0600); push(3'd2, 16'h0000); push(3'd3, 16'h5000);
    run(4'b1111, 21, 16);
    do_reset();
    push(3'd0, 16'h0003); push(3'd3, 16'h5000); push(3'd0, 16'h0003); push(3'd3, 16'h5000);
    run(4'b1001, 21, 16);
    // adder never answers
    do_reset();
    tie_off = 1;
    req = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("timeout_err", err, 32'(c == 8));
      chk("timeout_res_valid", res_valid, 0);
      if (c == 1) req = '0;
    end
    tie_off = 0;
    push(3'd3, 16'h5000);
    run(4'b1011, 6, 1);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
